// File: rtl/led_cube_pkg.sv
// Shared constants for the LED cube: voxel geometry, animation ids and sequencer state encoding.
`timescale 1ns/1ps
package led_cube_pkg;

    localparam int unsigned COORD_W  = 4;
    localparam int unsigned COLOR_W  = 4;
    localparam int unsigned CUBE_DIM = 8;

    localparam int unsigned ANIM_COUNTDOWN = 0;
    localparam int unsigned ANIM_GAME      = 1;
    localparam int unsigned ANIM_IDLE_RAIN = 2;
    localparam int unsigned ANIM_IDLE_SPIN = 3;

    typedef enum logic [1:0] {
        StIdle,
        StArst,
        StRun,
        StClear
    } seq_state_e;

endpackage

// File: rtl/seq_play_fifo.sv
// Small synchronous FIFO holding queued animation play requests.
`timescale 1ns/1ps
module seq_play_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push && !full) begin
                wptr_q <= wptr_q + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rptr_q <= rptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/led_anim_sequencer.sv
// Runs one animation engine at a time on the cube's voxel port, then blanks the cube.
`timescale 1ns/1ps
module led_anim_sequencer
    import led_cube_pkg::*;
#(
    parameter int unsigned N_ANIM      = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned QDEPTH      = 4,
    parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        play_valid,
    input  logic [ID_W-1:0]             play_id,
    output logic                        play_ready,
    output logic [N_ANIM-1:0]           anim_rstn,
    output logic [N_ANIM-1:0]           anim_en,
    input  logic [N_ANIM-1:0]           anim_done,
    input  logic [N_ANIM-1:0]           anim_vox_en,
    input  logic [N_ANIM*COORD_W-1:0]   anim_vox_x,
    input  logic [N_ANIM*COORD_W-1:0]   anim_vox_y,
    input  logic [N_ANIM*COORD_W-1:0]   anim_vox_z,
    input  logic [N_ANIM*COLOR_W-1:0]   anim_vox_c,
    output logic                        led_en,
    output logic [COORD_W-1:0]          led_x,
    output logic [COORD_W-1:0]          led_y,
    output logic [COORD_W-1:0]          led_z,
    output logic [COLOR_W-1:0]          led_c,
    output logic                        busy,
    output logic [ID_W-1:0]             cur_id,
    output logic                        err_timeout,
    output logic                        err_badid
);

    localparam logic [COORD_W-1:0] LastCoord = COORD_W'(CUBE_DIM - 1);

    seq_state_e          state_q;
    logic [ID_W-1:0]     cur_id_q;
    logic [31:0]         run_cnt_q;
    logic [N_ANIM-1:0]   anim_rstn_q;
    logic [N_ANIM-1:0]   anim_en_q;
    logic                led_en_q;
    logic [COORD_W-1:0]  led_x_q;
    logic [COORD_W-1:0]  led_y_q;
    logic [COORD_W-1:0]  led_z_q;
    logic [COLOR_W-1:0]  led_c_q;
    logic                err_timeout_q;
    logic                err_badid_q;

    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ID_W-1:0]     fifo_rdata;
    logic                bad_id;
    logic                timeout_hit;
    logic                sweep_last;

    logic [N_ANIM-1:0]   cur_onehot;
    logic [N_ANIM-1:0]   pop_onehot;
    logic                sel_done;
    logic                sel_vox_en;
    logic [COORD_W-1:0]  sel_x;
    logic [COORD_W-1:0]  sel_y;
    logic [COORD_W-1:0]  sel_z;
    logic [COLOR_W-1:0]  sel_c;

    assign fifo_pop = (state_q == StIdle) && !fifo_empty;

    seq_play_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (ID_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (play_valid),
        .wdata  (play_id),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign bad_id      = 32'(fifo_rdata) >= N_ANIM;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (run_cnt_q == 32'(TIMEOUT_CYC - 1));
    assign sweep_last  = (led_x_q == LastCoord) && (led_y_q == LastCoord) &&
                         (led_z_q == LastCoord);

    always_comb begin
        cur_onehot = '0;
        pop_onehot = '0;
        sel_done   = 1'b0;
        sel_vox_en = 1'b0;
        sel_x      = '0;
        sel_y      = '0;
        sel_z      = '0;
        sel_c      = '0;
        for (int i = 0; i < N_ANIM; i++) begin
            cur_onehot[i] = (cur_id_q == ID_W'(i));
            pop_onehot[i] = (fifo_rdata == ID_W'(i));
            if (cur_onehot[i]) begin
                sel_done   = anim_done[i];
                sel_vox_en = anim_vox_en[i];
                sel_x      = anim_vox_x[i*COORD_W +: COORD_W];
                sel_y      = anim_vox_y[i*COORD_W +: COORD_W];
                sel_z      = anim_vox_z[i*COORD_W +: COORD_W];
                sel_c      = anim_vox_c[i*COLOR_W +: COLOR_W];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            cur_id_q      <= '0;
            run_cnt_q     <= '0;
            anim_rstn_q   <= '1;
            anim_en_q     <= '0;
            led_en_q      <= 1'b0;
            led_x_q       <= '0;
            led_y_q       <= '0;
            led_z_q       <= '0;
            led_c_q       <= '0;
            err_timeout_q <= 1'b0;
            err_badid_q   <= 1'b0;
        end else begin
            anim_rstn_q   <= '1;
            err_timeout_q <= 1'b0;
            err_badid_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        cur_id_q <= fifo_rdata;
                        if (bad_id) begin
                            err_badid_q <= 1'b1;
                        end else begin
                            anim_rstn_q <= ~pop_onehot;
                            state_q     <= StArst;
                        end
                    end
                end
                StArst: begin
                    anim_en_q <= cur_onehot;
                    run_cnt_q <= '0;
                    state_q   <= StRun;
                end
                StRun: begin
                    led_en_q  <= sel_vox_en;
                    led_x_q   <= sel_x;
                    led_y_q   <= sel_y;
                    led_z_q   <= sel_z;
                    led_c_q   <= sel_c;
                    run_cnt_q <= run_cnt_q + 32'd1;
                    if (sel_done || timeout_hit) begin
                        // Done takes priority; the engine is only reset on a real timeout.
                        if (!sel_done) begin
                            err_timeout_q <= 1'b1;
                            anim_rstn_q   <= ~cur_onehot;
                        end
                        anim_en_q <= '0;
                        led_en_q  <= 1'b1;
                        led_x_q   <= '0;
                        led_y_q   <= '0;
                        led_z_q   <= '0;
                        led_c_q   <= '0;
                        state_q   <= StClear;
                    end
                end
                StClear: begin
                    if (sweep_last) begin
                        led_en_q <= 1'b0;
                        led_x_q  <= '0;
                        led_y_q  <= '0;
                        led_z_q  <= '0;
                        state_q  <= StIdle;
                    end else if (led_x_q != LastCoord) begin
                        led_x_q <= led_x_q + COORD_W'(1);
                    end else begin
                        led_x_q <= '0;
                        if (led_y_q != LastCoord) begin
                            led_y_q <= led_y_q + COORD_W'(1);
                        end else begin
                            led_y_q <= '0;
                            led_z_q <= led_z_q + COORD_W'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign play_ready  = !fifo_full;
    assign busy        = (state_q != StIdle) || !fifo_empty;
    assign cur_id      = cur_id_q;
    assign anim_rstn   = anim_rstn_q;
    assign anim_en     = anim_en_q;
    assign led_en      = led_en_q;
    assign led_x       = led_x_q;
    assign led_y       = led_y_q;
    assign led_z       = led_z_q;
    assign led_c       = led_c_q;
    assign err_timeout = err_timeout_q;
    assign err_badid   = err_badid_q;

endmodule
